// File: rtl/tlm_if.sv
// tlm_if: lamp drives and controls into the monitor, decoded phase/fault status out.
interface tlm_if #(
  parameter int DWELL_W = 8
);
  logic grn1, ylw1, red1, grn2, ylw2, red2, fm, clr_flt;
  logic [2:0] phase;
  logic phase_stb;
  logic [DWELL_W-1:0] dwell;
  logic fault;
  logic [2:0] fault_code;
  modport master (
    output grn1, ylw1, red1, grn2, ylw2, red2, fm, clr_flt,
    input phase, phase_stb, dwell, fault, fault_code
  );
  modport slave (
    input grn1, ylw1, red1, grn2, ylw2, red2, fm, clr_flt,
    output phase, phase_stb, dwell, fault, fault_code
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: checks lamp patterns, phase sequencing and yellow length; TLM_FLASH_EN adds flash mode.
module traffic_light_monitor #(
  parameter int MIN_YLW = 3,
  parameter int DWELL_W = 8
) (
  input logic ck,
  input logic clrn,
  tlm_if.slave m
);
  typedef enum logic [1:0] {
    IDLE,
    TRACK,
`ifdef TLM_FLASH_EN
    FAULT,
    FLASH
`else
    FAULT
`endif
  } state_t;
  state_t st;
  logic [2:0] phase, code, p, c;
  logic stb, fault, mal, conf, chg, ok, short_y;
  logic [DWELL_W-1:0] dwell, dinc;
  logic [7:0] ycnt, yinc;
  always_comb begin
    mal = !($onehot({m.grn1, m.ylw1, m.red1}) && $onehot({m.grn2, m.ylw2, m.red2}));
    conf = !m.red1 && !m.red2;
    p = !m.red1 ? (m.grn1 ? 3'd0 : 3'd1) : !m.red2 ? (m.grn2 ? 3'd2 : 3'd3) : 3'd4;
    chg = p != phase;
    ok = (phase == 3'd0 && p == 3'd1) || (phase == 3'd1 && (p == 3'd2 || p == 3'd4)) ||
         (phase == 3'd2 && p == 3'd3) || (phase == 3'd3 && (p == 3'd0 || p == 3'd4)) ||
         (phase == 3'd4 && (p == 3'd0 || p == 3'd2));
    short_y = (phase == 3'd1 || phase == 3'd3) && ycnt < 8'(MIN_YLW);
    c = mal ? 3'd1 : conf ? 3'd2 : (chg && !ok) ? 3'd3 : (chg && short_y) ? 3'd4 : 3'd0;
    dinc = dwell + DWELL_W'(!(&dwell));
    yinc = ycnt + 8'(!(&ycnt));
  end
  // ycnt counts samples spent in the current phase; only consulted when leaving yellow
  always_ff @(posedge ck or negedge clrn) begin
    if (!clrn) begin
      st <= IDLE;
      phase <= 3'd7;
      stb <= 1'b0;
      dwell <= '0;
      fault <= 1'b0;
      code <= 3'd0;
      ycnt <= 8'd0;
    end else begin
      stb <= 1'b0;
`ifdef TLM_FLASH_EN
      if (m.fm && (st == IDLE || st == TRACK)) begin
        st <= FLASH;
        phase <= 3'd5;
        dwell <= '0;
      end else if (st == FLASH) begin
        if (!m.fm) begin
          st <= IDLE;
          phase <= 3'd7;
          dwell <= '0;
        end else dwell <= dinc;
      end else
`endif
      if (st == FAULT) begin
        if (m.clr_flt) begin
          if (mal || conf) code <= mal ? 3'd1 : 3'd2;
          else begin
            st <= IDLE;
            fault <= 1'b0;
            code <= 3'd0;
            dwell <= '0;
          end
        end
      end else if (st == IDLE) begin
        if (!mal && !conf) begin
          st <= TRACK;
          phase <= p;
          dwell <= '0;
          ycnt <= 8'd1;
        end
      end else if (c != 3'd0) begin
        st <= FAULT;
        fault <= 1'b1;
        code <= c;
        phase <= 3'd7;
      end else if (chg) begin
        phase <= p;
        stb <= 1'b1;
        dwell <= '0;
        ycnt <= 8'd1;
      end else begin
        dwell <= dinc;
        ycnt <= yinc;
      end
    end
  end
`ifndef TLM_FLASH_EN
  logic unused_fm;
  assign unused_fm = m.fm;
`endif
  assign m.phase = phase;
  assign m.phase_stb = stb;
  assign m.dwell = dwell;
  assign m.fault = fault;
  assign m.fault_code = code;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed lamp sequences checked against a timestamp-based model and literals.
module tb_traffic_light_monitor;
  localparam int MIN_YLW = 3;
  localparam int DW = 8;
  localparam logic [5:0] P0 = 6'b100001, P1 = 6'b010001, P2 = 6'b001100,
                         P3 = 6'b001010, P4 = 6'b001001, GG = 6'b100100, OFF = 6'b000000;
  logic ck = 1'b0, clrn = 1'b0;
  tlm_if #(.DWELL_W(DW)) bus ();
  traffic_light_monitor #(.MIN_YLW(MIN_YLW), .DWELL_W(DW)) dut (.ck(ck), .clrn(clrn), .m(bus.slave));
  always #5 ck = ~ck;
  int checks = 0, errors = 0;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  function automatic bit allowed(int a, int b);
    return (a * 8 + b) inside {1, 10, 12, 19, 24, 28, 32, 34};
  endfunction
  // model: 0 idle, 1 track, 2 fault; dwell and yellow length derived from entry timestamp
  int mst, cyc, tent, mdw, l1, l2, np, fc;
  logic [2:0] mph, mcode;
  logic mstb, mflt;
  bit mal, conf;
  always @(posedge ck or negedge clrn) begin
    if (!clrn) begin
      mst = 0; mph = 7; mstb = 0; mdw = 0; mflt = 0; mcode = 0; cyc = 0; tent = 0;
    end else begin
      cyc++;
      l1 = int'(bus.grn1) + int'(bus.ylw1) + int'(bus.red1);
      l2 = int'(bus.grn2) + int'(bus.ylw2) + int'(bus.red2);
      mal = l1 != 1 || l2 != 1;
      conf = !bus.red1 && !bus.red2;
      np = (bus.red1 && bus.red2) ? 4 : bus.red2 ? (bus.grn1 ? 0 : 1) : (bus.grn2 ? 2 : 3);
      mstb = 0;
      if (mst == 0) begin
        if (!mal && !conf) begin mst = 1; mph = 3'(np); mdw = 0; tent = cyc; end
      end else if (mst == 1) begin
        fc = mal ? 1 : conf ? 2 : (np != mph && !allowed(mph, np)) ? 3 :
             (np != mph && (mph == 1 || mph == 3) && cyc - tent < MIN_YLW) ? 4 : 0;
        if (fc != 0) begin mst = 2; mflt = 1; mcode = 3'(fc); mph = 7; end
        else if (np != mph) begin mph = 3'(np); mstb = 1; mdw = 0; tent = cyc; end
        else mdw = (cyc - tent > 255) ? 255 : cyc - tent;
      end else if (bus.clr_flt) begin
        if (mal || conf) mcode = mal ? 3'd1 : 3'd2;
        else begin mst = 0; mflt = 0; mcode = 0; mdw = 0; end
      end
    end
  end
  always @(negedge ck) if (clrn) begin
    chk("cmp_phase", 32'(bus.phase), 32'(mph));
    chk("cmp_stb", 32'(bus.phase_stb), 32'(mstb));
    chk("cmp_dwell", 32'(bus.dwell), 32'(mdw));
    chk("cmp_fault", 32'(bus.fault), 32'(mflt));
    chk("cmp_code", 32'(bus.fault_code), 32'(mcode));
  end
  task automatic apply(logic [5:0] p, int n, logic c = 1'b0);
    for (int i = 0; i < n; i++) begin
      {bus.grn1, bus.ylw1, bus.red1, bus.grn2, bus.ylw2, bus.red2} = p;
      bus.clr_flt = c;
      @(negedge ck);
    end
    bus.clr_flt = 1'b0;
  endtask
  task automatic chk_reset(string n);
    chk({n, "_phase"}, 32'(bus.phase), 7);
    chk({n, "_stb"}, 32'(bus.phase_stb), 0);
    chk({n, "_dwell"}, 32'(bus.dwell), 0);
    chk({n, "_fault"}, 32'(bus.fault), 0);
    chk({n, "_code"}, 32'(bus.fault_code), 0);
  endtask
  initial begin
    bus.fm = 1'b0;
    bus.clr_flt = 1'b0;
    {bus.grn1, bus.ylw1, bus.red1, bus.grn2, bus.ylw2, bus.red2} = OFF;
    @(negedge ck);
    chk_reset("reset");
    clrn = 1'b1;
    apply(P0, 4);
    chk("seq_g_phase", 32'(bus.phase), 0);
    chk("seq_g_dwell", 32'(bus.dwell), 3);
    apply(P1, 1);
    chk("seq_y_stb", 32'(bus.phase_stb), 1);
    apply(P1, 2);
    chk("seq_y_phase", 32'(bus.phase), 1);
    chk("seq_y_dwell", 32'(bus.dwell), 2);
    apply(P4, 2);
    chk("seq_rr_phase", 32'(bus.phase), 4);
    chk("seq_rr_dwell", 32'(bus.dwell), 1);
    apply(P2, 1);
    chk("seq_rg_phase", 32'(bus.phase), 2);
    chk("seq_rg_stb", 32'(bus.phase_stb), 1);
    chk("seq_fault", 32'(bus.fault), 0);
    apply(P3, 3);
    apply(P0, 2);
    apply(GG, 1);
    chk("conf_fault", 32'(bus.fault), 1);
    chk("conf_code", 32'(bus.fault_code), 2);
    chk("conf_phase", 32'(bus.phase), 7);
    apply(P0, 10);
    chk("conf_hold_code", 32'(bus.fault_code), 2);
    chk("conf_hold_dwell", 32'(bus.dwell), 1);
    apply(P0, 1, 1'b1);
    apply(P0, 1);
    apply(P1, 2);
    apply(P2, 1);
    chk("short_y_code", 32'(bus.fault_code), 4);
    apply(P2, 1, 1'b1);
    chk("clr_fault", 32'(bus.fault), 0);
    chk("clr_idle_phase", 32'(bus.phase), 7);
    apply(P2, 1);
    chk("clr_track_phase", 32'(bus.phase), 2);
    chk("clr_track_stb", 32'(bus.phase_stb), 0);
    apply(P3, 3);
    apply(P0, 1);
    apply(P3, 1);
    chk("bad_trans_code", 32'(bus.fault_code), 3);
    apply(P0, 1, 1'b1);
    apply(P0, 1);
    apply(OFF, 1);
    chk("prio_mal_code", 32'(bus.fault_code), 1);
    apply(GG, 1, 1'b1);
    chk("reclr_conf_code", 32'(bus.fault_code), 2);
    chk("reclr_conf_fault", 32'(bus.fault), 1);
    apply(P0, 1, 1'b1);
    apply(P0, 1);
    apply(P0, 300);
    chk("sat_dwell", 32'(bus.dwell), 255);
    apply(P1, 2);
    #2 clrn = 1'b0;
    #1 chk_reset("async_rst");
    @(negedge ck);
    clrn = 1'b1;
    chk("rel_idle_phase", 32'(bus.phase), 7);
    apply(P1, 3);
    apply(P2, 1);
    chk("rel_phase", 32'(bus.phase), 2);
    chk("rel_fault", 32'(bus.fault), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
